kernel_window_2d: RTL and testbench
===================================

// Module: kernel_window_2d
// PURPOSE
//  Parametrised 2D sliding-window generator for the HOG front end. Takes a raster-order
//  pixel stream (valid/ready) and emits a KERNEL_H x KERNEL_W window per in-image position.
//  Uses KERNEL_H-1 line buffers plus per-row column shift registers.
//  Feeds gradient/convolution stages; generalises the 1D kernel shift register to 2D,
//  adding frame-position tracking and border suppression.
// PARAMETERS
//  DATA_WIDTH  8    bits per pixel
//  KERNEL_W    3    window width in pixels (>=2)
//  KERNEL_H    3    window height in rows (>=2)
//  IMG_WIDTH   640  pixels per image row (>=KERNEL_W)
//  IMG_HEIGHT  480  rows per frame (>=KERNEL_H)
// PORTS
//  clk        in   1                           clock, all logic on rising edge
//  rst        in   1                           synchronous, active-high reset
//  in_data    in   DATA_WIDTH                  pixel, raster order
//  in_valid   in   1                           in_data valid
//  in_ready   out  1                           block accepts a pixel this cycle
//  out_data   out  DATA_WIDTH*KERNEL_W*KERNEL_H  packed window
//  out_valid  out  1                           out_data valid
//  out_ready  in   1                           downstream accepts window
//  out_last   out  1                           window is last of frame (bottom-right)
// BEHAVIOUR
//  - Reset: out_valid=0, out_last=0, out_data=0, col/row counters=0; in_ready=1 after reset.
//    Line-buffer and shift-register contents are not cleared; stale data is never emitted.
//  - Handshake:
//    - in_ready = !out_valid || out_ready (combinational); accept = in_valid && in_ready.
//    - out_valid/out_data/out_last hold stable while out_valid && !out_ready.
//  - On accept, pixel P at (row r, col c):
//    - Column-c line-buffer entries shift upward; P enters the bottom row.
//    - Each row's KERNEL_W shift register shifts left with that row's column-c pixel.
//    - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
//    - At (IMG_HEIGHT-1, IMG_WIDTH-1) both counters wrap to 0 for the next frame.
//  - Latency 1 cycle: if r>=KERNEL_H-1 and c>=KERNEL_W-1, the cycle after accept has
//    out_valid=1 and the window ends at P.
//    - Otherwise out_valid=0 the cycle after accept, provided out_valid was 0 or the
//      previous window was consumed.
//  - No window straddles a row edge or frame edge: border positions are suppressed, not padded.
//  - Windows per frame: (IMG_HEIGHT-KERNEL_H+1)*(IMG_WIDTH-KERNEL_W+1).
//  - Packing: element (i,j) at out_data[((i*KERNEL_W)+j)*DATA_WIDTH +: DATA_WIDTH].
//    i=0 is the top (oldest) row; j=0 is the leftmost (oldest) column.
//  - out_last=1 only with the window whose newest pixel is (IMG_HEIGHT-1, IMG_WIDTH-1).
//  - No accept (in_valid=0 or stalled): counters, buffers and shift registers hold.
//    If out_valid && out_ready with no accept, out_valid drops to 0 next cycle.
//  - Simultaneous output consume and input accept: the new window replaces the old one
//    in one cycle; full throughput of 1 pixel/cycle.
//  - Reset mid-frame: counters return to 0; the next accepted pixel is (0,0) of a new frame.
//    No output until KERNEL_H-1 full rows have been re-accepted.
//  - Line buffers: circular, indexed by col, depth IMG_WIDTH; a read and a write to the
//    same entry occur in the same accept cycle (read-before-write).
// TESTING (IMG_WIDTH=5, IMG_HEIGHT=4, 3x3, DATA_WIDTH=8, pixel value = raster index)
//  1. Stream 0..19, out_ready=1.
//     -> first out_valid the cycle after 12 is accepted; window = {0,1,2,5,6,7,10,11,12}.
//     -> 6 windows total.
//  2. Same stream -> last window {7,8,9,12,13,14,17,18,19} with out_last=1.
//     -> out_last=0 on the other 5 windows.
//  3. Hold out_ready=0 for 4 cycles while a window is valid.
//     -> in_ready=0, out_data stable, no pixel lost.
//     -> Resume gives the same 6-window sequence.
//  4. Random in_valid gaps (~50%), out_ready=1.
//     -> Window contents and count identical to scenario 1.
//  5. Two back-to-back frames (values 0..19 then 100..119).
//     -> Frame 2 first window {100,101,102,105,106,107,110,111,112}.
//     -> No window contains frame-1 data.
//  6. Assert rst after pixel 8, then stream 0..19.
//     -> out_valid=0 during reset; outputs as in scenario 1.

Source files
------------

// File: rtl/kernel_window_2d_if.sv
// Stream bundle for the 2D window generator: pixel stream in, packed window stream out.
// The design side uses the slave modport and the producer/consumer side uses master.
interface kernel_window_2d_if #(
   parameter int DATA_WIDTH = 8,
   parameter int KERNEL_W   = 3,
   parameter int KERNEL_H   = 3
);
   logic [DATA_WIDTH-1:0]                     in_data;
   logic                                      in_valid;
   logic                                      in_ready;
   logic [DATA_WIDTH*KERNEL_W*KERNEL_H-1:0]   out_data;
   logic                                      out_valid;
   logic                                      out_ready;
   logic                                      out_last;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last
   );
endinterface

// File: rtl/kernel_window_2d.sv
// 2D sliding-window generator: KERNEL_H-1 column-indexed line buffers feed per-row
// KERNEL_W shift registers; windows touching a row or frame border are suppressed.
module kernel_window_2d #(
   parameter int DATA_WIDTH = 8,
   parameter int KERNEL_W   = 3,
   parameter int KERNEL_H   = 3,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic               clk,
   input  logic               rst,
   kernel_window_2d_if.slave  io_bus
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL_H - 1);

   logic [CW-1:0]                                    r_col;
   logic [RW-1:0]                                    r_row;
   logic [DATA_WIDTH-1:0]                            r_lb [KERNEL_H-1][IMG_WIDTH];
   logic [KERNEL_H-1:0][KERNEL_W-1:0][DATA_WIDTH-1:0] r_sr;
   logic                                             r_out_valid;
   logic                                             r_out_last;
   logic [DATA_WIDTH*KERNEL_W*KERNEL_H-1:0]          r_out_data;

   logic [KERNEL_H-1:0][DATA_WIDTH-1:0]              w_col;
   logic [KERNEL_H-1:0][KERNEL_W-1:0][DATA_WIDTH-1:0] w_win;
   logic w_in_ready, w_accept, w_in_win, w_col_end, w_frame_end;

   assign w_in_ready  = !r_out_valid || io_bus.out_ready;
   assign w_accept    = io_bus.in_valid && w_in_ready;
   assign w_in_win    = (r_row >= ROW_MIN) && (r_col >= COL_MIN);
   assign w_col_end   = (r_col == COL_LAST);
   assign w_frame_end = w_col_end && (r_row == ROW_LAST);

   // Column vector at the current col: buffered rows on top (oldest first), new pixel last.
   // The window is formed from the post-shift view so it ends exactly at the incoming pixel.
   for (genvar i = 0; i < KERNEL_H; i++) begin : g_row
      if (i < KERNEL_H - 1) begin : g_buf
         assign w_col[i] = r_lb[i][r_col];
      end else begin : g_new
         assign w_col[i] = io_bus.in_data;
      end
      for (genvar j = 0; j < KERNEL_W; j++) begin : g_tap
         if (j < KERNEL_W - 1) begin : g_old
            assign w_win[i][j] = r_sr[i][j+1];
         end else begin : g_cur
            assign w_win[i][j] = w_col[i];
         end
      end
   end

   // Storage is deliberately not reset; border suppression keeps stale contents from escaping.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int i = 0; i < KERNEL_H - 1; i++)
            r_lb[i][r_col] <= w_col[i+1];
         for (int i = 0; i < KERNEL_H; i++) begin
            for (int j = 0; j < KERNEL_W - 1; j++)
               r_sr[i][j] <= r_sr[i][j+1];
            r_sr[i][KERNEL_W-1] <= w_col[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col       <= '0;
         r_row       <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else if (w_accept) begin
         r_col <= w_col_end ? '0 : r_col + 1'b1;
         if (w_col_end)
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
         r_out_valid <= w_in_win;
         r_out_last  <= w_in_win && w_frame_end;
         if (w_in_win)
            r_out_data <= w_win;
      end else if (io_bus.out_ready) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end
   end

   assign io_bus.in_ready  = w_in_ready;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.out_last  = r_out_last;
   assign io_bus.out_data  = r_out_data;
endmodule

// File: tb/tb_kernel_window_2d.sv
// Directed bench for kernel_window_2d on a 5x4 image with a 3x3 kernel; a reference
// image model pushes expected windows on accept, popped when the DUT hands one over.
module tb_kernel_window_2d;
   localparam int DW = 8, KW = 3, KH = 3, IW = 5, IH = 4;
   localparam int OW = DW * KW * KH;

   typedef struct {
      logic [OW-1:0] data;
      logic          last;
   } win_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   kernel_window_2d_if #(.DATA_WIDTH(DW), .KERNEL_W(KW), .KERNEL_H(KH)) bus ();

   kernel_window_2d #(
      .DATA_WIDTH(DW), .KERNEL_W(KW), .KERNEL_H(KH), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   int            n_checks = 0;
   int            n_err    = 0;
   int            cyc      = 0;
   win_t          q[$];
   logic [OW-1:0] win_log[$];
   logic [DW-1:0] img [IH][IW];
   int            mr = 0, mc = 0;
   logic          exp_valid = 1'b0;
   logic          held_ok = 1'b0;
   logic [OW-1:0] held_data = '0;

   task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Window whose top-left pixel holds value tl, with raster-index pixel values.
   function automatic logic [OW-1:0] win_at(input int tl);
      logic [OW-1:0] r;
      r = '0;
      for (int i = 0; i < KH; i++)
         for (int j = 0; j < KW; j++)
            r[((i*KW)+j)*DW +: DW] = DW'(tl + i*IW + j);
      return r;
   endfunction

   task automatic model_clear();
      q.delete();
      mr = 0; mc = 0;
      exp_valid = 1'b0;
      held_ok = 1'b0;
   endtask

   task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy, output logic acc);
      win_t e;
      @(negedge clk);
      bus.in_valid = v; bus.in_data = d; bus.out_ready = rdy;
      #1;
      cyc++;
      chk("out_valid", bus.out_valid, exp_valid);
      chk("in_ready", bus.in_ready, !exp_valid || rdy);
      if (held_ok) chk("stall_hold", bus.out_data, held_data);
      held_ok   = bus.out_valid && !rdy;
      held_data = bus.out_data;
      if (bus.out_valid && rdy) begin
         if (q.size() == 0) chk("spurious_window", bus.out_valid, 1'b0);
         else begin
            e = q.pop_front();
            chk("win_data", bus.out_data, e.data);
            chk("win_last", bus.out_last, e.last);
            win_log.push_back(bus.out_data);
         end
      end
      acc = v && (!exp_valid || rdy);
      if (acc) begin
         img[mr][mc] = d;
         if (mr >= KH-1 && mc >= KW-1) begin
            for (int i = 0; i < KH; i++)
               for (int j = 0; j < KW; j++)
                  e.data[((i*KW)+j)*DW +: DW] = img[mr-KH+1+i][mc-KW+1+j];
            e.last = (mr == IH-1) && (mc == IW-1);
            q.push_back(e);
            exp_valid = 1'b1;
         end else exp_valid = 1'b0;
         if (mc == IW-1) begin
            mc = 0;
            mr = (mr == IH-1) ? 0 : mr + 1;
         end else mc++;
      end else if (exp_valid && rdy) exp_valid = 1'b0;
   endtask

   // Streams n pixels base..base+n-1; optional random gaps and a stall window [st0, st0+stn).
   task automatic stream(input int base, input int n, input bit gaps, input int st0, input int stn);
      int   p, guard;
      logic acc, v;
      p = 0; guard = 0;
      while (p < n && guard < 400) begin
         v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         step(v, DW'(base + p), !(cyc >= st0 && cyc < st0 + stn), acc);
         if (acc) p++;
         guard++;
      end
      chk("stream_done", OW'(p), OW'(n));
   endtask

   task automatic drain();
      logic acc;
      repeat (3) step(1'b0, '0, 1'b1, acc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.in_data = '0;
      repeat (2) begin
         @(negedge clk); #1;
         chk("rst_out_valid", bus.out_valid, 1'b0);
      end
      rst = 1'b0; #1;
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_data", bus.out_data, '0);
      chk("rst_out_last", bus.out_last, 1'b0);
      model_clear();
   endtask

   task automatic scen_end(input string tag, input int nwin);
      chk({tag, "_count"}, OW'(win_log.size()), OW'(nwin));
      chk({tag, "_sb_empty"}, OW'(q.size()), OW'(0));
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
      do_reset();

      // 1/2: plain stream, check first and last windows
      win_log.delete(); cyc = 0;
      stream(0, 20, 1'b0, -100, 0); drain();
      scen_end("s1", 6);
      if (win_log.size() == 6) begin
         chk("s1_first", win_log[0], win_at(0));
         chk("s2_last", win_log[5], win_at(7));
      end

      // 3: downstream stall right as the first window appears
      win_log.delete(); cyc = 0;
      stream(0, 20, 1'b0, 13, 4); drain();
      scen_end("s3", 6);
      if (win_log.size() == 6) chk("s3_first", win_log[0], win_at(0));

      // 4: random input gaps
      win_log.delete(); cyc = 0;
      stream(0, 20, 1'b1, -100, 0); drain();
      scen_end("s4", 6);
      if (win_log.size() == 6) chk("s4_last", win_log[5], win_at(7));

      // 5: two back-to-back frames
      win_log.delete(); cyc = 0;
      stream(0, 20, 1'b0, -100, 0);
      stream(100, 20, 1'b0, -100, 0); drain();
      scen_end("s5", 12);
      if (win_log.size() == 12) begin
         chk("s5_f2_first", win_log[6], win_at(100));
         chk("s5_f2_last", win_log[11], win_at(107));
      end

      // 6: reset mid-frame then a clean frame
      win_log.delete(); cyc = 0;
      stream(0, 9, 1'b0, -100, 0);
      do_reset();
      stream(0, 20, 1'b0, -100, 0); drain();
      scen_end("s6", 6);
      if (win_log.size() == 6) chk("s6_first", win_log[0], win_at(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
